// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq: byte-serial command sequencer for the DLFloat16 MAC core.
// Assembles 16-bit operands from a host byte stream and holds the accumulator.
// It launches the MAC core with a start/done handshake and streams the
// accumulator back to the host one byte at a time.
module dlfloat_mac_seq #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [15:0] mac_c,
    output logic        mac_start,
    input  logic        mac_done,
    input  logic [15:0] mac_result,
    output logic        busy,
    output logic        err,
    output logic [7:0]  mac_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_OPS,
        S_START,
        S_WAIT,
        S_SEND_HI,
        S_SEND_LO
    } state_t;

    localparam logic [7:0]       CMD_MAC  = 8'h01;
    localparam logic [7:0]       CMD_CLR  = 8'h02;
    localparam logic [7:0]       CMD_READ = 8'h03;
    localparam logic [7:0]       CMD_LOAD = 8'h04;
    // Counter value during the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             is_load_q, is_load_d;   // frame in GET_OPS is a LOAD
    logic [1:0]       bcnt_q, bcnt_d;         // payload byte index
    logic [7:0]       hold_q, hold_d;         // LOAD high byte awaiting its low byte
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [15:0]      acc_q, acc_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [7:0]       odata_q, odata_d;

    logic             in_fire;

    // Completed-MAC counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready  = rst_n & ena & ((state_q == S_IDLE) | (state_q == S_GET_OPS));
    assign in_fire   = in_valid & in_ready;

    assign out_valid = (state_q == S_SEND_HI) | (state_q == S_SEND_LO);
    assign out_data  = odata_q;
    assign mac_start = (state_q == S_START);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign mac_cnt   = cnt_q;
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign mac_c     = acc_q;

    // Next-state and datapath update: command decode, payload assembly, MAC wait, read-out.
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        bcnt_d    = bcnt_q;
        hold_d    = hold_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        odata_d   = odata_q;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    case (in_data)
                        CMD_MAC: begin
                            is_load_d = 1'b0;
                            bcnt_d    = 2'd0;
                            state_d   = S_GET_OPS;
                        end
                        CMD_LOAD: begin
                            is_load_d = 1'b1;
                            bcnt_d    = 2'd0;
                            state_d   = S_GET_OPS;
                        end
                        CMD_CLR: begin
                            acc_d = 16'h0000;
                            err_d = 1'b0;
                            cnt_d = 8'h00;
                        end
                        CMD_READ: begin
                            odata_d = acc_q[15:8];
                            state_d = S_SEND_HI;
                        end
                        default: begin
                            // Unknown command: flag it and treat the next byte as a command.
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            S_GET_OPS: begin
                if (in_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (is_load_q) begin
                        if (bcnt_q == 2'd0) begin
                            hold_d = in_data;
                        end else begin
                            acc_d   = {hold_q, in_data};
                            state_d = S_IDLE;
                        end
                    end else begin
                        case (bcnt_q)
                            2'd0: a_d[15:8] = in_data;
                            2'd1: a_d[7:0]  = in_data;
                            2'd2: b_d[15:8] = in_data;
                            default: begin
                                b_d[7:0] = in_data;
                                state_d  = S_START;
                            end
                        endcase
                    end
                end
            end

            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A result arriving in the last allowed cycle still counts.
                if (mac_done) begin
                    acc_d   = mac_result;
                    cnt_d   = sat_inc8(cnt_q);
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_SEND_HI: begin
                if (out_ready) begin
                    odata_d = acc_q[7:0];
                    state_d = S_SEND_LO;
                end
            end

            S_SEND_LO: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset clears everything so a partial frame or pending MAC is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            bcnt_q    <= 2'd0;
            hold_q    <= 8'h00;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            acc_q     <= 16'h0000;
            err_q     <= 1'b0;
            cnt_q     <= 8'h00;
            tmo_q     <= '0;
            odata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            bcnt_q    <= bcnt_d;
            hold_q    <= hold_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            odata_q   <= odata_d;
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Testbench for dlfloat_mac_seq: directed steps followed by randomized frames,
// checked against a command-level reference model of the accumulator,
// the error flag and the MAC count.
module tb_dlfloat_mac_seq;

    localparam int TIMEOUT = 64;
    localparam int BOUND   = 300;

    logic        clk = 1'b0;
    logic        rst_n, ena, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, mac_start, busy, err;
    logic [7:0]  out_data, mac_cnt;
    logic [15:0] mac_a, mac_b, mac_c;
    logic        mac_done   = 1'b0;
    logic [15:0] mac_result = 16'h0000;

    int n_assert = 0;
    int n_fail   = 0;

    // MAC core model controls: delay 0 means the core never answers.
    int          mdl_delay  = 3;
    logic [15:0] mdl_result = 16'h0000;
    int          dly        = 0;
    int          inj_req    = 0;
    int          inj_ack    = 0;
    logic [15:0] inj_result = 16'h0000;
    int          starts     = 0;
    logic [15:0] cap_a = 16'h0, cap_b = 16'h0, cap_c = 16'h0;

    // Reference state of the sequencer seen from the host.
    logic [15:0] ref_acc;
    logic        ref_err;
    int          ref_cnt;

    always #5 clk = ~clk;

    dlfloat_mac_seq #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_start  (mac_start),
        .mac_done   (mac_done),
        .mac_result (mac_result),
        .busy       (busy),
        .err        (err),
        .mac_cnt    (mac_cnt)
    );

    // MAC core stand-in: counts start pulses, latches operands, answers after mdl_delay cycles.
    always @(negedge clk) begin
        mac_done = 1'b0;
        if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                mac_done   = 1'b1;
                mac_result = mdl_result;
            end
        end
        if (inj_req != inj_ack) begin
            inj_ack    = inj_req;
            mac_done   = 1'b1;
            mac_result = inj_result;
        end
        if (mac_start) begin
            starts = starts + 1;
            cap_a  = mac_a;
            cap_b  = mac_b;
            cap_c  = mac_c;
            dly    = mdl_delay;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 32'(n), 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_wait", 32'(n), 32'd0);
        b = out_data;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait", 32'(n), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ref_acc = 16'h0000;
        ref_err = 1'b0;
        ref_cnt = 0;
    endtask

    task automatic do_mac(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input int delay);
        int          s0;
        logic [15:0] c0;
        s0         = starts;
        c0         = ref_acc;
        mdl_result = res;
        mdl_delay  = delay;
        send_byte(8'h01);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
        wait_idle();
        // A result counts only if it arrives within the allowed WAIT window.
        if (delay >= 1 && delay <= TIMEOUT) begin
            ref_acc = res;
            if (ref_cnt < 255) ref_cnt++;
        end else begin
            ref_err = 1'b1;
        end
        chk("mac_start_pulses", 32'(starts), 32'(s0 + 1));
        chk("mac_a", 32'(cap_a), 32'(a));
        chk("mac_b", 32'(cap_b), 32'(b));
        chk("mac_c", 32'(cap_c), 32'(c0));
        chk("mac_err", 32'(err), 32'(ref_err));
        chk("mac_cnt", 32'(mac_cnt), 32'(ref_cnt));
    endtask

    task automatic do_load(input logic [15:0] v);
        send_byte(8'h04);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
        ref_acc = v;
        chk("load_acc", 32'(mac_c), 32'(ref_acc));
        chk("load_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input string tag);
        logic [7:0] hi, lo;
        send_byte(8'h03);
        chk({tag, "_valid_early"}, 32'(out_valid), 32'd1);
        chk({tag, "_hi_early"}, 32'(out_data), 32'(ref_acc[15:8]));
        recv_byte(hi);
        recv_byte(lo);
        chk(tag, 32'({hi, lo}), 32'(ref_acc));
        chk({tag, "_cnt"}, 32'(mac_cnt), 32'(ref_cnt));
        chk({tag, "_err"}, 32'(err), 32'(ref_err));
    endtask

    task automatic do_clr();
        send_byte(8'h02);
        ref_acc = 16'h0000;
        ref_err = 1'b0;
        ref_cnt = 0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_cnt", 32'(mac_cnt), 32'd0);
        chk("clr_acc", 32'(mac_c), 32'd0);
    endtask

    task automatic do_illegal(input logic [7:0] c);
        int s0;
        s0 = starts;
        send_byte(c);
        ref_err = 1'b1;
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_busy", 32'(busy), 32'd0);
        chk("illegal_no_start", 32'(starts), 32'(s0));
    endtask

    // Hard stop in case something wedges the directed sequence.
    initial begin
        #800000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k, s0, pick, d;
        logic        err_seen;
        logic [7:0]  c, hi, lo;
        logic [15:0] a, b, r, v;

        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        ref_acc   = 16'h0000;
        ref_err   = 1'b0;
        ref_cnt   = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_mac_start", 32'(mac_start), 32'd0);
        chk("rst_mac_a",     32'(mac_a),     32'd0);
        chk("rst_mac_b",     32'(mac_b),     32'd0);
        chk("rst_mac_c",     32'(mac_c),     32'd0);
        chk("rst_mac_cnt",   32'(mac_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);

        // Basic MAC 01 3E 00 3E 00, core answers 0x3E00
        do_mac(16'h3E00, 16'h3E00, 16'h3E00, 3);
        do_read("read_after_mac");

        // Timeout: the core stays silent
        mdl_delay = 0;
        s0        = starts;
        v         = ref_acc;
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        k        = 0;
        err_seen = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (busy) err_seen = err_seen | err;
        end while (busy && k < BOUND);
        ref_err = 1'b1;
        chk("tmo_cycles",     32'(k),        32'(TIMEOUT + 2));
        chk("tmo_err_early",  32'(err_seen), 32'd0);
        chk("tmo_err",        32'(err),      32'd1);
        chk("tmo_in_ready",   32'(in_ready), 32'd1);
        chk("tmo_acc_kept",   32'(mac_c),    32'(v));
        chk("tmo_one_start",  32'(starts),   32'(s0 + 1));

        // Late mac_done while idle is ignored
        inj_result = 16'hBEEF;
        inj_req++;
        repeat (3) @(negedge clk);
        chk("late_done_busy", 32'(busy), 32'd0);
        do_read("read_after_late_done");

        // mac_done in the last WAIT cycle wins over the timeout
        do_clr();
        do_mac(16'h1111, 16'h2222, 16'h4242, TIMEOUT);
        do_read("read_done_at_limit");
        // One cycle too late: timeout, and the stray pulse that follows is ignored
        do_mac(16'h3333, 16'h4444, 16'h5555, TIMEOUT + 1);
        repeat (3) @(negedge clk);
        do_read("read_done_too_late");
        do_clr();

        // Backpressure on the read port
        do_load(16'hABCD);
        send_byte(8'h03);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'hAB);
        end
        recv_byte(hi);
        recv_byte(lo);
        chk("bp_bytes", 32'({hi, lo}), 32'hABCD);

        // Minimum READ frame with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        send_byte(8'h03);
        @(negedge clk);
        chk("fast_hi", 32'({out_valid, out_data}), 32'({1'b1, ref_acc[15:8]}));
        @(negedge clk);
        chk("fast_lo", 32'({out_valid, out_data}), 32'({1'b1, ref_acc[7:0]}));
        @(negedge clk);
        chk("fast_done", 32'({busy, out_valid}), 32'd0);
        out_ready = 1'b0;

        // Illegal command then CLR
        do_illegal(8'h7F);
        do_clr();
        do_read("read_after_clr");

        // Reset in the middle of a MAC frame
        s0 = starts;
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        do_load(16'h1234);
        do_read("read_after_midreset");
        chk("midreset_no_start", 32'(starts), 32'(s0));

        // ena low while idle: nothing is taken
        @(negedge clk);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ena_idle_ready", 32'(in_ready), 32'd0);
            chk("ena_idle_busy",  32'(busy),     32'd0);
        end
        in_valid = 1'b0;
        ena      = 1'b1;

        // ena low mid-LOAD: the partial frame survives the stall
        send_byte(8'h04);
        send_byte(8'h5A);
        @(negedge clk);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ena_mid_ready", 32'(in_ready), 32'd0);
            chk("ena_mid_busy",  32'(busy),     32'd1);
        end
        in_valid = 1'b0;
        ena      = 1'b1;
        send_byte(8'hC3);
        ref_acc = 16'h5AC3;
        do_read("read_after_ena_stall");

        // Randomized frames against the reference model
        for (int it = 0; it < 40; it++) begin
            pick = $urandom_range(0, 4);
            case (pick)
                0: begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    r = 16'($urandom);
                    d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                    do_mac(a, b, r, d);
                end
                1: do_load(16'($urandom));
                2: do_read("rand_read");
                3: do_clr();
                default: begin
                    c = 8'($urandom);
                    if (c >= 8'h01 && c <= 8'h04) c = c | 8'h80;
                    do_illegal(c);
                end
            endcase
        end
        do_read("rand_final_read");

        // mac_cnt saturates at 255
        do_clr();
        for (int i = 0; i < 257; i++) begin
            do_mac(16'($urandom), 16'($urandom), 16'($urandom), 1);
        end
        chk("cnt_saturated", 32'(mac_cnt), 32'd255);
        do_read("read_after_saturation");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dlfloat_mac_seq.md
# dlfloat_mac_seq

Byte-serial command sequencer for the DLFloat16 multiply-accumulate datapath. It assembles 16-bit DLFloat operands from an 8-bit host stream, holds the accumulator, and starts the MAC core through a start/done handshake. It streams the accumulator back to the host one byte at a time. It sits between the top-level pin mux (ui_in/uio) and the MAC arithmetic core inside tt_um_dlfloatmac.

## Interface
- TIMEOUT, 64: maximum cycles spent waiting for mac_done before abort (≥2).
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design enable; when low no host byte is accepted.
- in_data  in  8  host byte.
- in_valid  in  1  host byte present.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  8  result byte.
- out_valid  out  1  result byte present.
- out_ready  in  1  host consumes out_data when out_valid & out_ready.
- mac_a, mac_b, mac_c  out  16 each  MAC operands; mac_c is the accumulator.
- mac_start  out  1  one-cycle pulse launching the MAC.
- mac_done  in  1  MAC result valid (pulse).
- mac_result  in  16  MAC output A*B+C.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag.
- mac_cnt  out  8  count of completed MACs, saturates at 255.

## Operation
- Frame = command byte followed by payload bytes. Multi-byte values are sent MSB first.
- 0x01 MAC takes 4 payload bytes: A_hi, A_lo, B_hi, B_lo. The block then computes acc ← A*B+acc.
- 0x02 CLR takes no payload. It sets acc ← 0, err ← 0 and mac_cnt ← 0.
- 0x03 READ takes no payload. It returns acc_hi, then acc_lo, on the out port.
- 0x04 LOAD takes 2 payload bytes and sets acc ← {hi,lo}.
- Any other command byte sets err ← 1 and is dropped. The next byte is decoded as a command.
- States:
  - IDLE: accepts a command byte.
  - GET_OPS: accepts payload; a byte counter runs 0..3.
  - START: mac_start=1 for exactly one cycle.
  - WAIT: waits for mac_done.
  - SEND_HI and SEND_LO: drive the output bytes.
- Transitions:
  - IDLE→GET_OPS on 0x01/0x04. IDLE→SEND_HI on 0x03. CLR and illegal commands stay in IDLE.
  - GET_OPS→START after the 4th MAC byte. GET_OPS→IDLE after the 2nd LOAD byte, with acc written on that edge.
  - START→WAIT unconditionally.
  - WAIT→IDLE on mac_done: acc ← mac_result and mac_cnt increments (saturating).
  - WAIT→IDLE on timeout: after TIMEOUT cycles in WAIT without mac_done, err ← 1 and acc is unchanged.
  - SEND_HI→SEND_LO on out handshake. SEND_LO→IDLE on out handshake.
- in_ready = rst_n & ena & (state==IDLE | state==GET_OPS).
- out_valid=1 exactly in SEND_HI/SEND_LO. out_data stays stable while out_valid & !out_ready.
- mac_a, mac_b and mac_c are held constant from START until leaving WAIT. mac_c equals acc.
- mac_done is sampled only in WAIT. A pulse in any other state is ignored.
- mac_done and timeout in the same cycle: mac_done wins, and err is not set.
- ena low in mid-frame only stalls intake; the partial frame is kept. ena does not affect WAIT or SEND states.
- Reset at any point discards any partial frame or pending MAC and returns the FSM to IDLE.

## Timing
- Reset values (after the first edge with rst_n low):
  - state IDLE; acc, mac_a, mac_b = 0; mac_cnt 0.
  - err, mac_start, out_valid, busy = 0; out_data 0.
  - in_ready is 0 while rst_n low.
- Byte accepted on edge n → its effect is visible in registers at n+1.
- 4th MAC payload byte accepted at edge n:
  - mac_start is high during cycle n..n+1 only.
  - The earliest valid mac_done is at edge n+2.
  - acc is updated on the edge where mac_done is sampled.
- READ accepted at edge n → out_valid rises after edge n, with out_data=acc[15:8].
- Minimum READ frame is 3 cycles when out_ready is held high.
- Timeout: err rises on the edge ending the TIMEOUT-th WAIT cycle.

## Test plan
- MAC: reset, then send 01 3E 00 3E 00. The MAC model returns 0x3E00 three cycles after mac_start.
  - Required: exactly one mac_start pulse; mac_a=mac_b=0x3E00, mac_c=0x0000.
  - Then send 03. Required: out bytes 3E, 00; mac_cnt=1.
- Timeout: send a MAC frame with the model silent. Required: err=1 after 64 WAIT cycles, acc unchanged, in_ready high again.
  - A late mac_done pulse in IDLE is ignored.
- Backpressure: LOAD 04 AB CD, then READ with out_ready low for 5 cycles. Required: out_data holds 0xAB with out_valid=1, then bytes AB, CD.
- Illegal command 0x7F, then 02. Required: err=1 with no mac_start, then err=0 and acc=0 after CLR.
- Reset mid-frame: send 01 11 22, then pulse rst_n low for one cycle. Then send 04 12 34 and 03. Required: no mac_start and read-back 12, 34.
- ena low with in_valid high for 10 cycles: in_ready stays 0 and no state change occurs.
